// File: rtl/fft_3_pkg.sv
// Shared definitions for the fft_3 datapath and its sequencer: state
// encoding, twiddle ROM geometry and the legal range of LOG2N.
package fft_3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned TW_IDX_W   = 3;
  localparam int unsigned TW_ENTRIES = 8;
  localparam int unsigned LOG2N_MIN  = 1;
  localparam int unsigned LOG2N_MAX  = 3;

  function automatic bit log2n_legal(input int unsigned l);
    return (l >= LOG2N_MIN) && (l <= LOG2N_MAX);
  endfunction

endpackage

// File: rtl/fft_seq_delay.sv
// Fixed-depth shift register with asynchronous clear. Carries the issued
// read (strobe, addresses, scale) forward to the write-back port.
module fft_seq_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  // Shift one slot per cycle, new entry enters at slot 0.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipeline registers; reset discards every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl_3.sv
// In-place radix-2 DIT FFT sequencer: issues butterfly read addresses and
// twiddle indices stage by stage, draining the butterfly pipeline between
// stages. Optional macro FFT_SEQ_SCALE_EN enables the per-stage 1/2 scale.
module fft_seq_ctrl_3
  import fft_3_pkg::*;
#(
  parameter int unsigned LOG2N  = 3,
  parameter int unsigned BF_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [LOG2N-1:0]    rd_addr_a,
  output logic [LOG2N-1:0]    rd_addr_b,
  output logic [TW_IDX_W-1:0] tw_index,
  output logic [1:0]          stage,
  output logic                wr_en,
  output logic [LOG2N-1:0]    wr_addr_a,
  output logic [LOG2N-1:0]    wr_addr_b,
  output logic                scale
);

  localparam int unsigned AW  = LOG2N;
  localparam int unsigned JW  = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam int unsigned CW  = $clog2(BF_LAT + 1);
  localparam int unsigned DLW = 2 * LOG2N + 2;

  localparam logic [JW-1:0] J_LAST     = JW'((2 ** (LOG2N - 1)) - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(BF_LAT - 1);
  localparam logic [1:0]    LAST_STAGE = 2'(LOG2N - 1);

  if (!log2n_legal(LOG2N) || (BF_LAT < 1) || ((2 ** TW_IDX_W) != TW_ENTRIES)) begin : g_param_err
    $error("fft_seq_ctrl_3: illegal LOG2N or BF_LAT");
  end

  seq_state_e          state_q, state_d;
  logic [JW-1:0]       j_q, j_d;
  logic [1:0]          s_q, s_d;
  logic                last_q, last_d;
  logic [CW-1:0]       drain_q, drain_d;

  logic                issue;
  logic [JW-1:0]       iss_j;
  logic [1:0]          iss_s;

  logic [AW-1:0]       jx, half, pos, grp, addr_a, addr_b;
  logic [TW_IDX_W-1:0] tw;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [AW-1:0]       rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0]       rd_addr_b_q, rd_addr_b_d;
  logic [TW_IDX_W-1:0] tw_q, tw_d;
  logic [1:0]          stage_q, stage_d;
  logic                scale_bit;

  logic [DLW-1:0]      dly_in, dly_out;
  logic                wr_scale_unused;

  // Next state and issue decision. The registered read port runs one cycle
  // behind this decision, so a butterfly is issued from IDLE (first of the
  // transform), from the final DRAIN cycle (first of the next stage) and
  // from RUN; last_q marks that the stage's final butterfly is on the port.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    last_d  = last_q;
    drain_d = drain_q;
    issue   = 1'b0;
    iss_j   = j_q;
    iss_s   = s_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          issue   = 1'b1;
          iss_j   = '0;
          iss_s   = '0;
          s_d     = '0;
        end
      end
      ST_RUN: begin
        if (last_q) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else if (!hold) begin
          issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (s_q == LAST_STAGE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            issue   = 1'b1;
            iss_j   = '0;
            iss_s   = s_q + 2'd1;
            s_d     = s_q + 2'd1;
          end
        end else begin
          drain_d = drain_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        s_d     = '0;
        j_d     = '0;
        last_d  = 1'b0;
        drain_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      if (iss_j == J_LAST) begin
        last_d = 1'b1;
        j_d    = '0;
      end else begin
        last_d = 1'b0;
        j_d    = iss_j + JW'(1);
      end
    end
  end

  // Butterfly address and twiddle index for the butterfly being issued.
  always_comb begin
    jx     = AW'(iss_j);
    half   = AW'(1) << iss_s;
    pos    = jx & (half - AW'(1));
    grp    = jx >> iss_s;
    addr_a = (grp << (iss_s + 2'd1)) | pos;
    addr_b = addr_a + half;
    tw     = TW_IDX_W'(pos) << (2'd2 - iss_s);
  end

  // Output register inputs: read-side fields only move on an issue.
  always_comb begin
    rd_en_d     = issue;
    rd_addr_a_d = issue ? addr_a : rd_addr_a_q;
    rd_addr_b_d = issue ? addr_b : rd_addr_b_q;
    tw_d        = issue ? tw     : tw_q;
    stage_d     = issue ? iss_s  : stage_q;
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      j_q         <= '0;
      s_q         <= '0;
      last_q      <= 1'b0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_q        <= '0;
      stage_q     <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      s_q         <= s_d;
      last_q      <= last_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_q        <= tw_d;
      stage_q     <= stage_d;
    end
  end

`ifdef FFT_SEQ_SCALE_EN
  logic scale_q, scale_d;

  // Halve on every stage: scale asserts with the first read and stays set.
  always_comb begin
    scale_d = issue ? 1'b1 : scale_q;
  end

  // Scale request register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scale_q <= 1'b0;
    else     scale_q <= scale_d;
  end

  assign scale_bit = scale_q;
`else
  assign scale_bit = 1'b0;
`endif

  assign dly_in = {rd_en_q, rd_addr_a_q, rd_addr_b_q, scale_bit};

  fft_seq_delay #(
    .DEPTH (BF_LAT),
    .WIDTH (DLW)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in),
    .dout (dly_out)
  );

  assign {wr_en, wr_addr_a, wr_addr_b, wr_scale_unused} = dly_out;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_index  = tw_q;
  assign stage     = stage_q;
  assign scale     = scale_bit;

endmodule

// File: tb/tb_fft_seq_ctrl_3.sv
// Directed bench for fft_seq_ctrl_3 with a read/write scoreboard; a default
// instance (LOG2N=3, BF_LAT=2) and a small one (LOG2N=2, BF_LAT=1).
module tb_fft_seq_ctrl_3;

  localparam int LA = 3, TA = 2;
  localparam int LB = 2, TB = 1;
`ifdef FFT_SEQ_SCALE_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start_a, start_b, hold_a, hold_b;

  logic busy_a, done_a, rd_en_a, wr_en_a, scale_a;
  logic [LA-1:0] ra_a, rb_a, wa_a, wb_a;
  logic [2:0] tw_a;
  logic [1:0] st_a;

  logic busy_b, done_b, rd_en_b, wr_en_b, scale_b;
  logic [LB-1:0] ra_b, rb_b, wa_b, wb_b;
  logic [2:0] tw_b;
  logic [1:0] st_b;

  fft_seq_ctrl_3 #(.LOG2N(LA), .BF_LAT(TA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .hold(hold_a),
    .busy(busy_a), .done(done_a), .rd_en(rd_en_a),
    .rd_addr_a(ra_a), .rd_addr_b(rb_a), .tw_index(tw_a), .stage(st_a),
    .wr_en(wr_en_a), .wr_addr_a(wa_a), .wr_addr_b(wb_a), .scale(scale_a)
  );

  fft_seq_ctrl_3 #(.LOG2N(LB), .BF_LAT(TB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hold(hold_b),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
    .rd_addr_a(ra_b), .rd_addr_b(rb_b), .tw_index(tw_b), .stage(st_b),
    .wr_en(wr_en_b), .wr_addr_a(wa_b), .wr_addr_b(wb_b), .scale(scale_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int sa = 0, sb = 0;
  int qa_rd[$], qb_rd[$], qa_wr[$], qb_wr[$];
  int rd_cnt_a = 0, wr_cnt_a = 0, done_cnt_a = 0;
  int rd_cnt_b = 0, wr_cnt_b = 0, done_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic flag(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=unexpected expected=none", tag);
  endtask

  // Reference: walk groups and in-group positions of each stage; the twiddle
  // exponent p of W_(2*half) maps to W8 index p*8/(2*half).
  function automatic void push_model(input bit sel, input int l);
    int n = 1 << l;
    for (int s = 0; s < l; s++) begin
      int half = 1 << s;
      for (int g = 0; g < n; g += 2 * half) begin
        for (int p = 0; p < half; p++) begin
          int e = (g + p) * 1000 + (g + p + half) * 100 + (p * 8 / (2 * half)) * 10 + s;
          if (sel) qb_rd.push_back(e);
          else     qa_rd.push_back(e);
        end
      end
    end
  endfunction

  always @(negedge clk) begin : mon_a
    int enc;
    if (rd_en_a === 1'b1) begin
      rd_cnt_a++;
      enc = int'(ra_a) * 1000 + int'(rb_a) * 100 + int'(tw_a) * 10 + int'(st_a);
      if (qa_rd.size() == 0) flag("rd_a_extra");
      else check("rd_a", enc, qa_rd.pop_front());
      check("scale_a", scale_a, SC);
      qa_wr.push_back((cyc + TA) * 100 + int'(ra_a) * 10 + int'(rb_a));
    end
    if (wr_en_a === 1'b1) begin
      wr_cnt_a++;
      enc = cyc * 100 + int'(wa_a) * 10 + int'(wb_a);
      if (qa_wr.size() == 0) flag("wr_a_extra");
      else check("wr_a", enc, qa_wr.pop_front());
    end
    if (done_a === 1'b1) done_cnt_a++;
  end

  always @(negedge clk) begin : mon_b
    int enc;
    if (rd_en_b === 1'b1) begin
      rd_cnt_b++;
      enc = int'(ra_b) * 1000 + int'(rb_b) * 100 + int'(tw_b) * 10 + int'(st_b);
      if (qb_rd.size() == 0) flag("rd_b_extra");
      else check("rd_b", enc, qb_rd.pop_front());
      check("scale_b", scale_b, SC);
      qb_wr.push_back((cyc + TB) * 100 + int'(ra_b) * 10 + int'(rb_b));
    end
    if (wr_en_b === 1'b1) begin
      wr_cnt_b++;
      enc = cyc * 100 + int'(wa_b) * 10 + int'(wb_b);
      if (qb_wr.size() == 0) flag("wr_b_extra");
      else check("wr_b", enc, qb_wr.pop_front());
    end
    if (done_b === 1'b1) done_cnt_b++;
  end

  // Pulse start for one sampling edge; returns at the negedge of cycle 1.
  task automatic start_go(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    if (sel) begin sb = cyc; start_b = 1'b0; end
    else     begin sa = cyc; start_a = 1'b0; end
  endtask

  task automatic go_to_a(input int c);
    while ((cyc - sa + 1) < c) @(negedge clk);
  endtask

  task automatic wait_done(input bit sel, output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!sel && done_a === 1'b1) begin at = cyc - sa + 1; break; end
      if (sel && done_b === 1'b1) begin at = cyc - sb + 1; break; end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {busy_a, done_a, rd_en_a, wr_en_a, scale_a, ra_a, rb_a, wa_a, wb_a, tw_a, st_a}, 0);
    check({tag, "_b"}, {busy_b, done_b, rd_en_b, wr_en_b, scale_b, ra_b, rb_b, wa_b, wb_b, tw_b, st_b}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain transform, with an ignored start pulse in cycle 5.
    push_model(1'b0, LA);
    start_go(1'b0);
    check("busy_c1", busy_a, 1'b1);
    check("rd_en_c1", rd_en_a, 1'b1);
    go_to_a(5); start_a = 1'b1;
    go_to_a(6); start_a = 1'b0;
    wait_done(1'b0, at);
    check("done_cyc_plain", at, 19);
    check("busy_at_done", busy_a, 1'b0);
    check("rd_q_empty", qa_rd.size(), 0);
    check("wr_q_empty", qa_wr.size(), 0);

    // Start held across the done cycle: only accepted the cycle after.
    push_model(1'b0, LA);
    start_a = 1'b1;
    @(negedge clk);
    check("busy_c20", busy_a, 1'b0);
    check("rd_en_c20", rd_en_a, 1'b0);
    check("rd_cnt_plain", rd_cnt_a, 12);
    check("wr_cnt_plain", wr_cnt_a, 12);
    check("done_cnt_plain", done_cnt_a, 1);
    rd_cnt_a = 0; wr_cnt_a = 0; done_cnt_a = 0;
    @(negedge clk);
    sa = cyc; start_a = 1'b0;
    check("busy_restart", busy_a, 1'b1);

    // Hold for three edges in the middle of stage 1.
    go_to_a(8); hold_a = 1'b1;
    go_to_a(9);
    check("hold_rd_c9", rd_en_a, 1'b0);
    check("hold_wr_c9", wr_en_a, 1'b1);
    go_to_a(10);
    check("hold_rd_c10", rd_en_a, 1'b0);
    check("hold_wr_c10", wr_en_a, 1'b1);
    go_to_a(11); hold_a = 1'b0;
    check("hold_rd_c11", rd_en_a, 1'b0);
    wait_done(1'b0, at);
    check("done_cyc_hold", at, 22);
    repeat (3) @(negedge clk);
    check("rd_cnt_hold", rd_cnt_a, 12);
    check("wr_cnt_hold", wr_cnt_a, 12);
    check("done_cnt_hold", done_cnt_a, 1);
    rd_cnt_a = 0; wr_cnt_a = 0; done_cnt_a = 0;

    // Asynchronous reset mid-transform, then a clean restart.
    push_model(1'b0, LA);
    start_go(1'b0);
    go_to_a(8);
    check("rd_en_before_rst", rd_en_a, 1'b1);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    qa_rd.delete(); qa_wr.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_cnt_a = 0; wr_cnt_a = 0; done_cnt_a = 0;
    push_model(1'b0, LA);
    start_go(1'b0);
    check("stage_after_rst", st_a, 2'd0);
    wait_done(1'b0, at);
    check("done_cyc_rst", at, 19);
    repeat (3) @(negedge clk);
    check("rd_cnt_rst", rd_cnt_a, 12);
    check("wr_cnt_rst", wr_cnt_a, 12);

    // Small configuration.
    push_model(1'b1, LB);
    start_go(1'b1);
    wait_done(1'b1, at);
    check("done_cyc_small", at, 7);
    repeat (3) @(negedge clk);
    check("rd_cnt_small", rd_cnt_b, 4);
    check("wr_cnt_small", wr_cnt_b, 4);
    check("done_cnt_small", done_cnt_b, 1);
    check("rd_q_small", qb_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
